// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INCR      = 32'd4;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push/pop/flush, count and full/empty.
// Head reads as zero when empty; no write-to-read bypass.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign dout  = empty ? '0 : mem_q[rd_q];

  always_comb begin
    do_pop  = pop && !empty;
    // a pop frees the slot a full-FIFO push writes into
    do_push = push && (!full || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = nxt(wr_q);
      if (do_pop)  rd_d = nxt(rd_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem reads, instruction buffer, redirect.
// Define IFETCH_PERF_CNT_EN to add perf_fetched/perf_flushed/perf_stall.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_en,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] instr_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [WIDTH-1:0] perf_fetched,
  output logic [WIDTH-1:0] perf_flushed,
  output logic [WIDTH-1:0] perf_stall
`endif
);
  localparam int BW  = 2 * WIDTH;
  localparam int BCW = $clog2(FIFO_DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;

  logic [BW-1:0]    buf_dout;
  logic [BCW-1:0]   buf_cnt;
  logic             buf_full;
  logic             buf_empty;
  logic [WIDTH-1:0] pcq_head;
  logic [OCW-1:0]   osd_cnt;
  logic             pcq_full;
  logic             pcq_empty;

  logic             credit_ok;
  logic             rsp_acc;
  logic             rsp_keep;
  logic             pop_fire;
  logic             osd_left;

  assign imem_addr   = pc_q;
  assign instr_valid = !buf_empty;
  assign instr_out   = buf_dout[BW-1:WIDTH];
  assign instr_pc    = buf_dout[WIDTH-1:0];
  assign pop_fire    = instr_valid && instr_ready;

  // buffered plus in-flight words never exceed the buffer size
  assign credit_ok = !buf_full &&
    ((32'(osd_cnt) + 32'(buf_cnt)) < 32'(FIFO_DEPTH));

  assign imem_req = !rst && (state_q == RUN) && fetch_en &&
    !redirect_valid && !pcq_full && credit_ok;

  assign rsp_acc  = imem_rvalid && !pcq_empty;
  assign rsp_keep = rsp_acc && (state_q == RUN) && !redirect_valid;
  assign osd_left = (osd_cnt - OCW'(rsp_acc)) != '0;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
      if (state_q != IDLE) state_d = osd_left ? FLUSH : RUN;
    end else begin
      if (imem_req) pc_d = pc_q + WIDTH'(PC_INCR);
      unique case (state_q)
        IDLE:    if (fetch_en) state_d = RUN;
        FLUSH:   if (!osd_left) state_d = RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .W     (BW),
    .DEPTH (FIFO_DEPTH)
  ) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .din   ({imem_rdata, pcq_head}),
    .pop   (pop_fire),
    .flush (redirect_valid),
    .dout  (buf_dout),
    .count (buf_cnt),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // request PCs, matched in order to returning read data
  fetch_fifo #(
    .W     (WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pcq (
    .clk   (clk),
    .rst   (rst),
    .push  (imem_req),
    .din   (pc_q),
    .pop   (rsp_acc),
    .flush (1'b0),
    .dout  (pcq_head),
    .count (osd_cnt),
    .full  (pcq_full),
    .empty (pcq_empty)
  );

`ifdef IFETCH_PERF_CNT_EN
  logic [WIDTH-1:0] fetched_q, fetched_d;
  logic [WIDTH-1:0] flushed_q, flushed_d;
  logic [WIDTH-1:0] stall_q, stall_d;

  always_comb begin
    fetched_d = fetched_q + WIDTH'(pop_fire);
    flushed_d = flushed_q + WIDTH'(rsp_acc && !rsp_keep);
    if (redirect_valid)
      flushed_d = flushed_d + WIDTH'(buf_cnt) - WIDTH'(pop_fire);
    stall_d = stall_q +
      WIDTH'((state_q == RUN) && instr_ready && !instr_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
  assign perf_stall   = stall_q;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a transaction-level model
// with an in-order, variable-latency instruction memory.
module tb_instr_fetch;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
  logic [31:0] perf_stall;
`endif

  instr_fetch #(
    .WIDTH           (32),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rsp_t;

  ent_t        buf_m[$];
  logic [31:0] pcq_m[$];
  rsp_t        memq[$];
  bit          run_m;
  int          disc_m;
  logic [31:0] pc_m;
  logic [31:0] pf_m, pl_m, ps_m;
  int          cyc;
  int          last_due;
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    run_m  = 1'b0;
    disc_m = 0;
    pc_m   = RST_PC;
    buf_m.delete();
    pcq_m.delete();
    memq.delete();
    pf_m = 0;
    pl_m = 0;
    ps_m = 0;
  endtask

  task automatic step(input bit r, input bit fe, input bit rd,
                      input logic [31:0] rp, input bit rdy,
                      input int lmin, input int lmax);
    bit          req_e;
    bit          acc;
    bit          keep;
    logic [31:0] rpc;
    int          d;
    rst            = r;
    fetch_en       = fe;
    redirect_valid = rd;
    redirect_pc    = rp;
    instr_ready    = rdy;
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memq[0].d;
      void'(memq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    req_e = !r && run_m && disc_m == 0 && fe && !rd &&
      pcq_m.size() < MAXO && (pcq_m.size() + buf_m.size()) < DEPTH;
    check("imem_req", 64'(imem_req), 64'(req_e));
    check("imem_addr", 64'(imem_addr), 64'(pc_m));
    check("instr_valid", 64'(instr_valid), 64'(buf_m.size() != 0));
    check("instr_out", 64'(instr_out),
          64'(buf_m.size() != 0 ? buf_m[0].d : 32'h0));
    check("instr_pc", 64'(instr_pc),
          64'(buf_m.size() != 0 ? buf_m[0].p : 32'h0));
`ifdef IFETCH_PERF_CNT_EN
    check("perf_fetched", 64'(perf_fetched), 64'(pf_m));
    check("perf_flushed", 64'(perf_flushed), 64'(pl_m));
    check("perf_stall", 64'(perf_stall), 64'(ps_m));
`endif
    if (imem_req && !r) begin
      d = cyc + int'($urandom_range(lmax, lmin));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      memq.push_back('{d, mem_word(imem_addr)});
    end
    if (r) begin
      model_reset();
    end else begin
      acc = imem_rvalid && pcq_m.size() != 0;
      if (run_m && disc_m == 0 && rdy && buf_m.size() == 0) ps_m++;
      if (buf_m.size() != 0 && rdy) begin
        void'(buf_m.pop_front());
        pf_m++;
      end
      if (acc) begin
        rpc  = pcq_m.pop_front();
        keep = run_m && disc_m == 0 && !rd;
        if (keep) begin
          buf_m.push_back('{imem_rdata, rpc});
        end else begin
          pl_m++;
          if (disc_m > 0) disc_m--;
        end
      end
      if (rd) begin
        pl_m += 32'(buf_m.size());
        buf_m.delete();
        pc_m = {rp[31:2], 2'b00};
        if (run_m) disc_m = pcq_m.size();
      end else begin
        if (req_e) begin
          pcq_m.push_back(pc_m);
          pc_m = pc_m + 32'd4;
        end
        if (!run_m && fe) run_m = 1'b1;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    cyc            = 0;
    last_due       = 0;
    rst            = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    instr_ready    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // idle after reset, then streaming with latency 1
    step(0, 0, 0, 0, 1, 1, 1);
    repeat (30) step(0, 1, 0, 0, 1, 1, 1);
    // back-pressure fills the buffer, then drains in order
    repeat (12) step(0, 1, 0, 0, 0, 1, 1);
    repeat (20) step(0, 1, 0, 0, 1, 1, 1);
    // latency 3 with requests in flight, redirect to 0x100
    repeat (10) step(0, 1, 0, 0, 1, 3, 3);
    step(0, 1, 1, 32'h100, 1, 3, 3);
    repeat (20) step(0, 1, 0, 0, 1, 3, 3);
    // redirect while data streams every cycle; low bits dropped
    repeat (10) step(0, 1, 0, 0, 1, 1, 1);
    step(0, 1, 1, 32'h203, 1, 1, 1);
    repeat (15) step(0, 1, 0, 0, 1, 1, 1);
    // partially filled buffer flushed by redirect, no pops
    repeat (3) step(0, 1, 0, 0, 0, 1, 1);
    step(0, 1, 1, 32'h400, 0, 1, 1);
    repeat (4) step(0, 1, 0, 0, 0, 1, 1);
    // reset mid-stream with buffered words
    step(1, 1, 0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 0, 1, 1, 1);
    // wrap-around of the PC
    step(0, 1, 1, 32'hFFFF_FFF4, 1, 1, 2);
    repeat (20) step(0, 1, 0, 0, 1, 1, 2);
    // pause issue while in RUN
    repeat (6) step(0, 0, 0, 0, 1, 1, 2);
    repeat (6) step(0, 1, 0, 0, 1, 1, 2);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(299, 0) == 0,
           $urandom_range(99, 0) < 85,
           $urandom_range(99, 0) < 3,
           $urandom,
           $urandom_range(99, 0) < 70,
           1, 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
